serial_byte_collector: RTL and testbench
========================================

# serial_byte_collector

Serial-to-parallel front end for the 8-way OR reduction stage: accepts one bit per clock over a valid/ready handshake, assembles bits LSB-first into a WIDTH-bit word, and presents each completed word on a registered, held-stable parallel bus for the downstream reducer. It provides one output holding slot with backpressure and a flush for zero-padded partial words. It also maintains a running count of emitted words.

## Interface
- WIDTH, 8, word width; must equal the downstream reducer input width (≥2)
- CNT_W, 16, width of the emitted-word counter
- clk  input  1  rising-edge clock, sole clock domain
- reset  input  1  synchronous, active-high; sampled on rising edge of clk
- bit_in  input  1  serial data bit
- bit_valid  input  1  bit_in is valid this cycle
- bit_ready  output  1  collector accepts bit_in this cycle (combinational)
- flush  input  1  single-cycle request to emit the current partial word
- word_out  output  WIDTH  assembled word, registered, drives the reducer input bus
- word_bits  output  $clog2(WIDTH+1)  number of real bits in word_out (1..WIDTH), registered
- word_valid  output  1  word_out/word_bits hold a word
- word_ready  input  1  downstream consumes the word this cycle
- word_count  output  CNT_W  words emitted since reset, wraps modulo 2^CNT_W

## Operation
- Internal state: assembly register asm[WIDTH-1:0], bit index cnt (0..WIDTH-1), output slot (word_out, word_bits, word_valid), flush_pend flag.
- Bit accept = bit_valid & bit_ready. On accept, bit_in is written to asm[cnt] and cnt increments; bit 0 is the first bit received.
- slot_free = !word_valid | word_ready (empty or draining this cycle).
- Full word: accept while cnt==WIDTH-1 loads word_out = {bit_in, asm[WIDTH-2:0]}, sets word_bits = WIDTH, word_valid = 1, clears asm to 0, and resets cnt to 0.
- bit_ready = !(cnt==WIDTH-1 & !slot_free). Ready is low only when the completing bit cannot be unloaded.
- Flush: a flush pulse sets flush_pend. This happens even when a bit is accepted in the same cycle; that bit is part of the flushed word.
- flush_pend executes at the first cycle where slot_free=1, cnt>0, and no full-word load occurs. It loads word_out = asm (unfilled bits are 0), sets word_bits = cnt, clears asm and cnt, and clears flush_pend.
- Flush with cnt==0 and no pending bits clears flush_pend and emits nothing.
- If a full word completes while flush_pend is set, the full word loads first and flush_pend is then discarded, because cnt is now 0.
- While flush_pend is set, bit acceptance continues normally.
- Output handshake: word_valid & word_ready consumes the word. word_valid drops next cycle unless a new load occurs in the same cycle (back-to-back).
- While word_valid=1 and word_ready=0, word_out and word_bits are held stable.
- word_count increments by 1 on every load into the slot (full or flush) and wraps to 0 after 2^CNT_W-1.

## Timing
- Reset (synchronous, dominates all other inputs): asm=0, cnt=0, flush_pend=0, word_out=0, word_bits=0, word_valid=0, word_count=0.
- Immediately after reset: bit_ready=1.
- Reset mid-word discards partial bits. Reset while word_valid=1 drops the word without handshake.
- Latency: word_valid rises on the clock edge that accepts the WIDTH-th bit, so it is visible the cycle after that bit is presented.
- Flush latency is 1 cycle when the slot is free and cnt>0.
- Throughput: sustained 1 bit/cycle with word_ready tied high. Words are emitted every WIDTH cycles with no gap.
- Backpressure: with word_ready=0, exactly WIDTH-1 further bits are accepted. bit_ready then stays low until word_ready=1, and the completing bit is accepted in that same cycle.
- All outputs except bit_ready are registered. bit_ready has a combinational path from word_ready.

## Test plan
- Reset then serial 1,0,0,0,0,0,0,1 on consecutive cycles, word_ready=1 -> word_out=8'h81, word_bits=8, word_valid high exactly 1 cycle, word_count=1.
- Continuous stream of 24 bits forming 8'h00, 8'hFF, 8'h5A with word_ready=1 -> three words on cycles 8, 16, 24 after first accept with no bubbles; word_count=3.
- Complete 8'hA5, hold word_ready=0, keep bit_valid=1 -> next 7 bits accepted, bit_ready low on the 8th. Word_out holds 8'hA5 throughout. Raise word_ready -> 8'hA5 consumed and next word loaded the same edge; bit_ready goes high.
- Send 3 bits 1,1,0 then flush -> word_out=8'h03, word_bits=3, cnt returns to 0. Flush with cnt==0 -> no word_valid, word_count unchanged.
- Flush pulse during backpressure with 4 bits pending -> word emitted only after the held word is consumed. Flush on the cycle the 8th bit is accepted -> full word only, no empty word follows.
- Assert reset mid-word (5 bits in) and while word_valid=1 -> all outputs 0 next cycle. Then a fresh 8 bits yield the correct word. With CNT_W=2, the 5th word wraps word_count to 1.

Source files
------------

// File: rtl/serial_byte_collector_if.sv
// Bit-side and word-side handshake bundle for serial_byte_collector.
// slave is the collector; master is the upstream/downstream side that drives it.
interface serial_byte_collector_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  localparam int BW = $clog2(WIDTH + 1);

  logic             bit_in;
  logic             bit_valid;
  logic             bit_ready;
  logic             flush;
  logic [WIDTH-1:0] word_out;
  logic [BW-1:0]    word_bits;
  logic             word_valid;
  logic             word_ready;
  logic [CNT_W-1:0] word_count;

  modport master (
    output bit_in, bit_valid, flush, word_ready,
    input  bit_ready, word_out, word_bits, word_valid, word_count
  );

  modport slave (
    input  bit_in, bit_valid, flush, word_ready,
    output bit_ready, word_out, word_bits, word_valid, word_count
  );
endinterface

// File: rtl/serial_byte_collector.sv
// Serial-to-parallel collector: LSB-first bit assembly into a WIDTH-bit word,
// single held output slot with backpressure, flush of zero-padded partial words.
module serial_byte_collector #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input logic                  clk,
  input logic                  reset,
  serial_byte_collector_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam int BW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] asm_q, asm_nxt;
  logic [CW-1:0]    cnt_q, cnt_nxt;
  logic             flush_pend_q, flush_pend_nxt;
  logic [WIDTH-1:0] word_out_q;
  logic [BW-1:0]    word_bits_q;
  logic             word_valid_q;
  logic [CNT_W-1:0] word_count_q;

  logic slot_free;
  logic at_last;
  logic bit_ready;
  logic accept;
  logic full_load;
  logic flush_exec;
  logic load;

  always_comb begin
    slot_free  = !word_valid_q || bus.word_ready;
    at_last    = (cnt_q == LAST);
    bit_ready  = !(at_last && !slot_free);
    accept     = bus.bit_valid && bit_ready;
    full_load  = accept && at_last;
    // a full-word load always wins; the pending flush then has nothing left to emit
    flush_exec = flush_pend_q && slot_free && (cnt_q != '0) && !full_load;
    load       = full_load || flush_exec;
  end

  always_comb begin
    asm_nxt = asm_q;
    cnt_nxt = cnt_q;
    if (full_load) begin
      asm_nxt = '0;
      cnt_nxt = '0;
    end else if (flush_exec) begin
      // a bit arriving on the flush cycle starts the next word
      asm_nxt = '0;
      cnt_nxt = '0;
      if (accept) begin
        asm_nxt[0] = bus.bit_in;
        cnt_nxt    = CW'(1);
      end
    end else if (accept) begin
      asm_nxt[cnt_q] = bus.bit_in;
      cnt_nxt        = cnt_q + CW'(1);
    end
  end

  always_comb begin
    flush_pend_nxt = flush_pend_q || bus.flush;
    if (flush_pend_q && (cnt_q == '0) && !bus.flush)
      flush_pend_nxt = 1'b0;
    if (flush_exec)
      flush_pend_nxt = bus.flush;
    if (full_load)
      flush_pend_nxt = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      asm_q        <= '0;
      cnt_q        <= '0;
      flush_pend_q <= 1'b0;
      word_out_q   <= '0;
      word_bits_q  <= '0;
      word_valid_q <= 1'b0;
      word_count_q <= '0;
    end else begin
      asm_q        <= asm_nxt;
      cnt_q        <= cnt_nxt;
      flush_pend_q <= flush_pend_nxt;
      if (full_load) begin
        word_out_q  <= {bus.bit_in, asm_q[WIDTH-2:0]};
        word_bits_q <= BW'(WIDTH);
      end else if (flush_exec) begin
        word_out_q  <= asm_q;
        word_bits_q <= BW'(cnt_q);
      end
      if (load)
        word_valid_q <= 1'b1;
      else if (bus.word_ready)
        word_valid_q <= 1'b0;
      if (load)
        word_count_q <= word_count_q + CNT_W'(1);
    end
  end

  assign bus.bit_ready  = bit_ready;
  assign bus.word_out   = word_out_q;
  assign bus.word_bits  = word_bits_q;
  assign bus.word_valid = word_valid_q;
  assign bus.word_count = word_count_q;
endmodule

// File: tb/tb_serial_byte_collector.sv
// Directed bench for serial_byte_collector: default instance plus a CNT_W=2 instance for wrap.
module tb_serial_byte_collector;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  serial_byte_collector_if #(.WIDTH(8), .CNT_W(16)) sb1 ();
  serial_byte_collector_if #(.WIDTH(8), .CNT_W(2))  sb2 ();

  serial_byte_collector #(.WIDTH(8), .CNT_W(16)) dut1 (.clk(clk), .reset(rst), .bus(sb1.slave));
  serial_byte_collector #(.WIDTH(8), .CNT_W(2))  dut2 (.clk(clk), .reset(rst), .bus(sb2.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic send1(input logic b);
    sb1.bit_valid = 1'b1;
    sb1.bit_in    = b;
    step();
    sb1.bit_valid = 1'b0;
  endtask

  task automatic send_word1(input logic [7:0] w);
    for (int i = 0; i < 8; i++) begin
      sb1.bit_valid = 1'b1;
      sb1.bit_in    = w[i];
      step();
    end
    sb1.bit_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    checks++; if (sb1.word_out !== 8'h00) begin failures++; $display("FAIL reset_word_out got=%h exp=00", sb1.word_out); end
    checks++; if (sb1.word_bits !== 4'd0) begin failures++; $display("FAIL reset_word_bits got=%0d exp=0", sb1.word_bits); end
    checks++; if (sb1.word_valid !== 1'b0) begin failures++; $display("FAIL reset_word_valid got=%b exp=0", sb1.word_valid); end
    checks++; if (sb1.word_count !== 16'd0) begin failures++; $display("FAIL reset_word_count got=%0d exp=0", sb1.word_count); end
    checks++; if (sb1.bit_ready !== 1'b1) begin failures++; $display("FAIL reset_bit_ready got=%b exp=1", sb1.bit_ready); end
  endtask

  task automatic test_basic();
    logic [7:0] w;
    w = 8'h81;
    do_reset();
    sb1.word_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sb1.bit_valid = 1'b1;
      sb1.bit_in    = w[i];
      step();
      if (i < 7) begin
        checks++; if (sb1.word_valid !== 1'b0) begin failures++; $display("FAIL basic_early_valid bit=%0d got=%b exp=0", i, sb1.word_valid); end
      end
    end
    sb1.bit_valid = 1'b0;
    checks++; if (sb1.word_out !== 8'h81) begin failures++; $display("FAIL basic_word got=%h exp=81", sb1.word_out); end
    checks++; if (sb1.word_bits !== 4'd8) begin failures++; $display("FAIL basic_bits got=%0d exp=8", sb1.word_bits); end
    checks++; if (sb1.word_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%b exp=1", sb1.word_valid); end
    checks++; if (sb1.word_count !== 16'd1) begin failures++; $display("FAIL basic_count got=%0d exp=1", sb1.word_count); end
    step();
    checks++; if (sb1.word_valid !== 1'b0) begin failures++; $display("FAIL basic_valid_drop got=%b exp=0", sb1.word_valid); end
  endtask

  task automatic test_back_to_back();
    logic [23:0] s;
    s = {8'h5A, 8'hFF, 8'h00};
    do_reset();
    sb1.word_ready = 1'b1;
    for (int k = 0; k < 24; k++) begin
      sb1.bit_valid = 1'b1;
      sb1.bit_in    = s[k];
      step();
      if ((k % 8) == 7) begin
        checks++; if (sb1.word_valid !== 1'b1 || sb1.word_out !== s[k-7 +: 8]) begin failures++; $display("FAIL stream_word k=%0d got=%b/%h exp=1/%h", k, sb1.word_valid, sb1.word_out, s[k-7 +: 8]); end
      end else begin
        checks++; if (sb1.word_valid !== 1'b0) begin failures++; $display("FAIL stream_gap k=%0d got=%b exp=0", k, sb1.word_valid); end
      end
    end
    sb1.bit_valid = 1'b0;
    checks++; if (sb1.word_count !== 16'd3) begin failures++; $display("FAIL stream_count got=%0d exp=3", sb1.word_count); end
  endtask

  task automatic test_backpressure();
    logic [7:0] w;
    w = 8'h3C;
    do_reset();
    sb1.word_ready = 1'b1;
    send_word1(8'hA5);
    checks++; if (sb1.word_valid !== 1'b1 || sb1.word_out !== 8'hA5) begin failures++; $display("FAIL bp_first got=%b/%h exp=1/a5", sb1.word_valid, sb1.word_out); end
    sb1.word_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      sb1.bit_valid = 1'b1;
      sb1.bit_in    = w[i];
      #1;
      checks++; if (sb1.bit_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_bit%0d got=%b exp=1", i, sb1.bit_ready); end
      step();
    end
    sb1.bit_valid = 1'b1;
    sb1.bit_in    = w[7];
    #1;
    checks++; if (sb1.bit_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_8th got=%b exp=0", sb1.bit_ready); end
    checks++; if (sb1.word_out !== 8'hA5) begin failures++; $display("FAIL bp_hold got=%h exp=a5", sb1.word_out); end
    step();
    step();
    checks++; if (sb1.word_out !== 8'hA5 || sb1.word_bits !== 4'd8 || sb1.word_valid !== 1'b1) begin failures++; $display("FAIL bp_hold_late got=%h/%0d/%b exp=a5/8/1", sb1.word_out, sb1.word_bits, sb1.word_valid); end
    checks++; if (sb1.word_count !== 16'd1) begin failures++; $display("FAIL bp_count_held got=%0d exp=1", sb1.word_count); end
    checks++; if (sb1.bit_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_stall got=%b exp=0", sb1.bit_ready); end
    sb1.word_ready = 1'b1;
    #1;
    checks++; if (sb1.bit_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_release got=%b exp=1", sb1.bit_ready); end
    step();
    sb1.bit_valid = 1'b0;
    checks++; if (sb1.word_out !== 8'h3C || sb1.word_valid !== 1'b1) begin failures++; $display("FAIL bp_next_word got=%h/%b exp=3c/1", sb1.word_out, sb1.word_valid); end
    checks++; if (sb1.word_count !== 16'd2) begin failures++; $display("FAIL bp_count got=%0d exp=2", sb1.word_count); end
    checks++; if (sb1.bit_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_after got=%b exp=1", sb1.bit_ready); end
  endtask

  task automatic test_flush();
    do_reset();
    sb1.word_ready = 1'b1;
    send1(1'b1);
    send1(1'b1);
    send1(1'b0);
    sb1.flush = 1'b1;
    step();
    sb1.flush = 1'b0;
    checks++; if (sb1.word_valid !== 1'b0) begin failures++; $display("FAIL flush_pending_valid got=%b exp=0", sb1.word_valid); end
    step();
    checks++; if (sb1.word_valid !== 1'b1 || sb1.word_out !== 8'h03) begin failures++; $display("FAIL flush_word got=%b/%h exp=1/03", sb1.word_valid, sb1.word_out); end
    checks++; if (sb1.word_bits !== 4'd3) begin failures++; $display("FAIL flush_bits got=%0d exp=3", sb1.word_bits); end
    checks++; if (sb1.word_count !== 16'd1) begin failures++; $display("FAIL flush_count got=%0d exp=1", sb1.word_count); end
    step();
    checks++; if (sb1.word_valid !== 1'b0) begin failures++; $display("FAIL flush_drop got=%b exp=0", sb1.word_valid); end
    sb1.flush = 1'b1;
    step();
    sb1.flush = 1'b0;
    step();
    step();
    checks++; if (sb1.word_valid !== 1'b0 || sb1.word_count !== 16'd1) begin failures++; $display("FAIL flush_empty got=%b/%0d exp=0/1", sb1.word_valid, sb1.word_count); end
    send_word1(8'h96);
    checks++; if (sb1.word_valid !== 1'b1 || sb1.word_out !== 8'h96 || sb1.word_bits !== 4'd8) begin failures++; $display("FAIL flush_cnt_cleared got=%b/%h/%0d exp=1/96/8", sb1.word_valid, sb1.word_out, sb1.word_bits); end
    checks++; if (sb1.word_count !== 16'd2) begin failures++; $display("FAIL flush_count2 got=%0d exp=2", sb1.word_count); end
  endtask

  task automatic test_flush_bp();
    logic [7:0] w;
    w = 8'h5A;
    do_reset();
    sb1.word_ready = 1'b1;
    send_word1(8'hA5);
    sb1.word_ready = 1'b0;
    send1(1'b1);
    send1(1'b0);
    send1(1'b1);
    send1(1'b1);
    sb1.flush = 1'b1;
    step();
    sb1.flush = 1'b0;
    step();
    checks++; if (sb1.word_out !== 8'hA5 || sb1.word_valid !== 1'b1 || sb1.word_count !== 16'd1) begin failures++; $display("FAIL fbp_held got=%h/%b/%0d exp=a5/1/1", sb1.word_out, sb1.word_valid, sb1.word_count); end
    sb1.word_ready = 1'b1;
    step();
    checks++; if (sb1.word_out !== 8'h0D || sb1.word_bits !== 4'd4 || sb1.word_valid !== 1'b1) begin failures++; $display("FAIL fbp_partial got=%h/%0d/%b exp=0d/4/1", sb1.word_out, sb1.word_bits, sb1.word_valid); end
    checks++; if (sb1.word_count !== 16'd2) begin failures++; $display("FAIL fbp_count got=%0d exp=2", sb1.word_count); end
    step();
    checks++; if (sb1.word_valid !== 1'b0) begin failures++; $display("FAIL fbp_drop got=%b exp=0", sb1.word_valid); end
    for (int i = 0; i < 8; i++) begin
      sb1.bit_valid = 1'b1;
      sb1.bit_in    = w[i];
      sb1.flush     = (i == 7);
      step();
    end
    sb1.bit_valid = 1'b0;
    sb1.flush     = 1'b0;
    checks++; if (sb1.word_out !== 8'h5A || sb1.word_bits !== 4'd8 || sb1.word_count !== 16'd3) begin failures++; $display("FAIL fbp_full got=%h/%0d/%0d exp=5a/8/3", sb1.word_out, sb1.word_bits, sb1.word_count); end
    step();
    checks++; if (sb1.word_valid !== 1'b0) begin failures++; $display("FAIL fbp_no_empty1 got=%b exp=0", sb1.word_valid); end
    step();
    checks++; if (sb1.word_valid !== 1'b0 || sb1.word_count !== 16'd3) begin failures++; $display("FAIL fbp_no_empty2 got=%b/%0d exp=0/3", sb1.word_valid, sb1.word_count); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    sb1.word_ready = 1'b1;
    for (int i = 0; i < 5; i++) send1(1'b1);
    do_reset();
    checks++; if (sb1.word_out !== 8'h00 || sb1.word_bits !== 4'd0 || sb1.word_valid !== 1'b0 || sb1.word_count !== 16'd0) begin failures++; $display("FAIL rmid_outputs got=%h/%0d/%b/%0d exp=00/0/0/0", sb1.word_out, sb1.word_bits, sb1.word_valid, sb1.word_count); end
    sb1.word_ready = 1'b0;
    send_word1(8'hA5);
    checks++; if (sb1.word_valid !== 1'b1 || sb1.word_out !== 8'hA5) begin failures++; $display("FAIL rmid_discard got=%b/%h exp=1/a5", sb1.word_valid, sb1.word_out); end
    do_reset();
    checks++; if (sb1.word_out !== 8'h00 || sb1.word_bits !== 4'd0 || sb1.word_valid !== 1'b0 || sb1.word_count !== 16'd0) begin failures++; $display("FAIL rvalid_outputs got=%h/%0d/%b/%0d exp=00/0/0/0", sb1.word_out, sb1.word_bits, sb1.word_valid, sb1.word_count); end
    sb1.word_ready = 1'b1;
    send_word1(8'h81);
    checks++; if (sb1.word_out !== 8'h81 || sb1.word_valid !== 1'b1 || sb1.word_count !== 16'd1) begin failures++; $display("FAIL rmid_fresh got=%h/%b/%0d exp=81/1/1", sb1.word_out, sb1.word_valid, sb1.word_count); end
  endtask

  task automatic test_wrap();
    logic [1:0] exp_cnt;
    do_reset();
    sb2.word_ready = 1'b1;
    for (int w = 0; w < 5; w++) begin
      for (int i = 0; i < 8; i++) begin
        sb2.bit_valid = 1'b1;
        sb2.bit_in    = 1'b1;
        step();
      end
      exp_cnt = 2'(w + 1);
      checks++; if (sb2.word_count !== exp_cnt || sb2.word_valid !== 1'b1 || sb2.word_out !== 8'hFF) begin failures++; $display("FAIL wrap_word%0d got=%0d/%b/%h exp=%0d/1/ff", w, sb2.word_count, sb2.word_valid, sb2.word_out, exp_cnt); end
    end
    sb2.bit_valid = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    sb1.bit_in = 1'b0; sb1.bit_valid = 1'b0; sb1.flush = 1'b0; sb1.word_ready = 1'b0;
    sb2.bit_in = 1'b0; sb2.bit_valid = 1'b0; sb2.flush = 1'b0; sb2.word_ready = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_flush_bp();
    test_reset_mid();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
